// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit controller among NUM_REQ byte producers.
// Define UART_TX_SCHED_TIMEOUT_EN to build in the ISSUE/ACTIVE watchdog (o_timeout).
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_ready,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [2:0]           o_grant_id,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} state_t;

  state_t     state_reg;
  logic [2:0] last_grant_reg;
  logic [2:0] grant_id_reg;
  logic [3:0] burst_cnt_reg;
  logic [7:0] tx_data_reg;
  logic       tx_ready_reg;
  logic       busy_reg;

  logic [7:0] valid_pad;
  logic [7:0] req_byte [8];
  logic [3:0] cand_sum [NUM_REQ];
  logic [2:0] cand_idx [NUM_REQ];
  logic       win_found;
  logic [2:0] win_idx;
  logic       accept;
  logic [2:0] sel_idx;
  logic [7:0] sel_byte;
  logic       wd_expired;

  // Pad requester vectors to 8 entries so a 3-bit index is always in range.
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_REQ-1:0] = i_req_valid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      if (gi < NUM_REQ) begin : g_used
        assign req_byte[gi] = i_req_data[8*gi +: 8];
      end else begin : g_unused
        assign req_byte[gi] = 8'h00;
      end
    end
    // Candidate gi is the requester gi+1 places after the last grant, modulo NUM_REQ.
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, last_grant_reg} + 4'(gi + 1);
      assign cand_idx[gi] = (cand_sum[gi] >= 4'(NUM_REQ)) ? 3'(cand_sum[gi] - 4'(NUM_REQ))
                                                         : cand_sum[gi][2:0];
    end
  endgenerate

  // Walk from the lowest-priority candidate up so the nearest valid one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_pad[cand_idx[i]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    accept  = 1'b0;
    sel_idx = grant_id_reg;
    case (state_reg)
      IDLE: begin
        accept  = win_found;
        sel_idx = win_idx;
      end
      DONE:    accept = valid_pad[grant_id_reg] && (burst_cnt_reg < 4'(MAX_BURST));
      default: accept = 1'b0;
    endcase
  end

  assign sel_byte = req_byte[sel_idx];

  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = accept && (sel_idx == 3'(i));
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;
  logic            wd_wait;
  logic            wd_progress;

  assign wd_wait     = (state_reg == ISSUE) || (state_reg == ACTIVE);
  assign wd_progress = ((state_reg == ISSUE) && i_tx_active) || ((state_reg == ACTIVE) && i_tx_done);
  assign wd_expired  = wd_wait && !wd_progress && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change, so each ISSUE/ACTIVE visit gets a full budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= wd_expired;
      if (wd_wait && !wd_progress && !wd_expired) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end else begin
        wd_cnt_reg <= '0;
      end
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign wd_expired = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 3'(NUM_REQ - 1);
      grant_id_reg   <= '0;
      burst_cnt_reg  <= '0;
      tx_data_reg    <= '0;
      tx_ready_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tx_data_reg    <= sel_byte;
            grant_id_reg   <= sel_idx;
            last_grant_reg <= sel_idx;
            burst_cnt_reg  <= 4'd1;
            tx_ready_reg   <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_tx_active) begin
            tx_ready_reg <= 1'b0;
            state_reg    <= ACTIVE;
          end else if (wd_expired) begin
            tx_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        ACTIVE: begin
          if (i_tx_done) begin
            state_reg <= DONE;
          end else if (wd_expired) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        DONE: begin
          // Only the current owner may continue; everyone else waits for IDLE.
          if (accept) begin
            tx_data_reg   <= sel_byte;
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
            tx_ready_reg  <= 1'b1;
            state_reg     <= ISSUE;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_reg;
  assign o_tx_ready = tx_ready_reg;
  assign o_grant_id = grant_id_reg;
  assign o_busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: producer queues, a transmitter model and a scoreboard of
// expected (grant, byte, issue gap) entries checked at every o_tx_ready rise.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int NUM_REQ        = 4;
  localparam int MAX_BURST      = 4;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int ACT_DLY        = 2;
  localparam int TX_LEN         = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_REQ-1:0]   i_req_valid = '0;
  logic [NUM_REQ*8-1:0] i_req_data = '0;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_ready;
  logic                 i_tx_active = 1'b0;
  logic                 i_tx_done = 1'b0;
  logic [2:0]           o_grant_id;
  logic                 o_busy;
  logic                 o_timeout;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_tx_data(o_tx_data), .o_tx_ready(o_tx_ready),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
    int         gap;  // observed cycles from i_tx_done to o_tx_ready rise; 0 = unchecked
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]         prod_mem [NUM_REQ][16];
  int                 prod_head [NUM_REQ];
  int                 prod_tail [NUM_REQ];
  logic [NUM_REQ-1:0] acc_pending = '0;
  bit                 model_en = 1'b1;
  int                 m_phase = 0;
  int                 m_cnt = 0;

  task automatic push_byte(input int k, input logic [7:0] b);
    prod_mem[k][prod_tail[k] % 16] = b;
    prod_tail[k]++;
  endtask

  task automatic push_exp(input int id, input logic [7:0] b, input int gap);
    exp_t e;
    e.id = 3'(id); e.data = b; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      prod_head[k] = 0;
      prod_tail[k] = 0;
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Producers: present the queue head; pop it on the negedge after a valid&ready edge.
  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      prod_head[k] = 0;
      prod_tail[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!reset) acc_pending[k] = 1'b0;
        if (acc_pending[k]) begin
          prod_head[k]++;
          acc_pending[k] = 1'b0;
        end
        if (prod_head[k] != prod_tail[k]) begin
          i_req_valid[k] = 1'b1;
          i_req_data[8*k +: 8] = prod_mem[k][prod_head[k] % 16];
        end else begin
          i_req_valid[k] = 1'b0;
        end
      end
      #1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (reset && i_req_valid[k] && o_req_ready[k]) acc_pending[k] = 1'b1;
      end
    end
  end

  // Transmitter: active ACT_DLY negedges after seeing ready, done pulse TX_LEN later.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset || !model_en) begin
        if (m_phase != 0) begin
          i_tx_active = 1'b0;
          i_tx_done   = 1'b0;
        end
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (o_tx_ready) begin m_phase = 1; m_cnt = ACT_DLY; end
          1: begin
            m_cnt--;
            if (m_cnt == 0) begin i_tx_active = 1'b1; m_phase = 2; m_cnt = TX_LEN; end
          end
          2: begin
            m_cnt--;
            if (m_cnt == 0) begin i_tx_active = 1'b0; i_tx_done = 1'b1; m_phase = 3; end
          end
          default: begin i_tx_done = 1'b0; m_phase = 0; end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    total++; if (o_tx_data !== 8'h00)  begin bad++; $display("FAIL rst_tx_data: got %h want 00", o_tx_data); end
    total++; if (o_tx_ready !== 1'b0)  begin bad++; $display("FAIL rst_tx_ready: got %b want 0", o_tx_ready); end
    total++; if (o_req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", o_req_ready); end
    total++; if (o_grant_id !== 3'd0)  begin bad++; $display("FAIL rst_grant_id: got %0d want 0", o_grant_id); end
    total++; if (o_busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    total++; if (o_timeout !== 1'b0)   begin bad++; $display("FAIL rst_timeout: got %b want 0", o_timeout); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    total++; if (o_busy !== 1'b0 || o_tx_ready !== 1'b0)
      begin bad++; $display("FAIL rst_idle: busy=%b tx_ready=%b want 0 0", o_busy, o_tx_ready); end
    $display("test_reset finished");
  endtask

  task automatic test_single();
    int   ready_cycles = 0;
    logic [NUM_REQ-1:0] ready_seen = '0;
    int   episodes = 0;
    bit   prev_rdy = 1'b0;
    int   done_cyc = -1;
    bit   finished = 1'b0;
    exp_t e;
    apply_reset();
    @(negedge clk); #2;
    push_exp(1, 8'hA5, 0);
    push_byte(1, 8'hA5);
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      @(negedge clk); #2;
      if (o_req_ready != '0) begin ready_cycles++; ready_seen = o_req_ready; end
      if (o_tx_ready && !prev_rdy) begin
        episodes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL single_extra_issue: grant=%0d data=%h", o_grant_id, o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (o_grant_id !== e.id || o_tx_data !== e.data) begin
            bad++; $display("FAIL single_issue: grant=%0d data=%h want grant=%0d data=%h", o_grant_id, o_tx_data, e.id, e.data);
          end
        end
      end
      prev_rdy = o_tx_ready;
      if (i_tx_done) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL single_busy_done: got %b want 1", o_busy); end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b want 0", o_busy); end
        finished = 1'b1;
      end
    end
    total++; if (!finished) begin bad++; $display("FAIL single_timeout: done_cyc=%0d want a done", done_cyc); end
    total++; if (ready_cycles != 1 || ready_seen !== 4'b0010)
      begin bad++; $display("FAIL single_ready: cycles=%0d value=%b want 1 0010", ready_cycles, ready_seen); end
    total++; if (episodes != 1) begin bad++; $display("FAIL single_episodes: got %0d want 1", episodes); end
    $display("test_single finished: episodes=%0d", episodes);
  endtask

  task automatic test_round_robin();
    bit   prev_rdy;
    int   done_cyc;
    exp_t e;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); #2;
      if (pass == 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          push_exp(k, 8'(8'hC0 + k), (k == 0) ? 0 : 3);
          push_byte(k, 8'(8'hC0 + k));
        end
      end else begin
        push_exp(0, 8'hD0, 0);
        push_exp(2, 8'hD2, 3);
        push_byte(2, 8'hD2);
        push_byte(0, 8'hD0);
      end
      prev_rdy = o_tx_ready;
      done_cyc = -100;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk); #2;
        if (o_req_ready != '0) begin
          total++;
          if (!$onehot(o_req_ready)) begin bad++; $display("FAIL rr_onehot: o_req_ready=%b want one-hot", o_req_ready); end
        end
        if (o_tx_ready && !prev_rdy) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rr_extra_issue: grant=%0d data=%h", o_grant_id, o_tx_data);
          end else begin
            e = exp_q.pop_front();
            if (o_grant_id !== e.id || o_tx_data !== e.data) begin
              bad++; $display("FAIL rr_issue: grant=%0d data=%h want grant=%0d data=%h", o_grant_id, o_tx_data, e.id, e.data);
            end
            if (e.gap != 0) begin
              total++;
              if (cyc - done_cyc != e.gap) begin bad++; $display("FAIL rr_gap: got %0d want %0d", cyc - done_cyc, e.gap); end
            end
          end
        end
        if (i_tx_done) done_cyc = cyc;
        prev_rdy = o_tx_ready;
        if (exp_q.size() == 0 && !o_busy && cyc > 0) break;
      end
      total++; if (exp_q.size() != 0 || o_busy)
        begin bad++; $display("FAIL rr_drain: pending=%0d busy=%b want 0 0", exp_q.size(), o_busy); end
    end
    $display("test_round_robin finished");
  endtask

  task automatic test_burst();
    bit   prev_rdy;
    int   done_cyc = -100;
    bit   loaded0 = 1'b0;
    exp_t e;
    apply_reset();
    @(negedge clk); #2;
    push_exp(2, 8'h10, 0); push_exp(2, 8'h11, 2); push_exp(2, 8'h12, 2); push_exp(2, 8'h13, 2);
    push_exp(0, 8'h77, 3); push_exp(2, 8'h14, 3); push_exp(2, 8'h15, 2);
    for (int b = 0; b < 6; b++) push_byte(2, 8'(8'h10 + b));
    prev_rdy = o_tx_ready;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk); #2;
      if (!loaded0 && o_busy) begin push_byte(0, 8'h77); loaded0 = 1'b1; end
      if (o_req_ready != '0) begin
        total++;
        if (!$onehot(o_req_ready)) begin bad++; $display("FAIL burst_onehot: o_req_ready=%b want one-hot", o_req_ready); end
      end
      if (o_tx_ready && !prev_rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL burst_extra_issue: grant=%0d data=%h", o_grant_id, o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (o_grant_id !== e.id || o_tx_data !== e.data) begin
            bad++; $display("FAIL burst_issue: grant=%0d data=%h want grant=%0d data=%h", o_grant_id, o_tx_data, e.id, e.data);
          end
          if (e.gap != 0) begin
            total++;
            if (cyc - done_cyc != e.gap) begin bad++; $display("FAIL burst_gap: data=%h got %0d want %0d", e.data, cyc - done_cyc, e.gap); end
          end
        end
      end
      if (i_tx_done) done_cyc = cyc;
      prev_rdy = o_tx_ready;
      if (exp_q.size() == 0 && !o_busy && cyc > 0) break;
    end
    total++; if (exp_q.size() != 0 || o_busy)
      begin bad++; $display("FAIL burst_drain: pending=%0d busy=%b want 0 0", exp_q.size(), o_busy); end
    $display("test_burst finished");
  endtask

  task automatic test_async_reset();
    bit   prev_rdy = 1'b0;
    bit   seen = 1'b0;
    int   done_cyc = -100;
    exp_t e;
    apply_reset();
    @(negedge clk); #2;
    push_exp(1, 8'h5A, 0);
    push_byte(1, 8'h5A);
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk); #2;
      if (o_tx_ready && !prev_rdy) seen = 1'b1;
      prev_rdy = o_tx_ready;
    end
    total++; if (!seen || o_busy !== 1'b1 || o_grant_id !== 3'd1 || o_tx_data !== 8'h5A)
      begin bad++; $display("FAIL arst_pre: seen=%b busy=%b grant=%0d data=%h want 1 1 1 5a", seen, o_busy, o_grant_id, o_tx_data); end
    #1 reset = 1'b0;
    #1;
    total++; if (o_tx_ready !== 1'b0 || o_busy !== 1'b0)
      begin bad++; $display("FAIL arst_ctrl: tx_ready=%b busy=%b want 0 0", o_tx_ready, o_busy); end
    total++; if (o_tx_data !== 8'h00 || o_grant_id !== 3'd0 || o_req_ready !== 4'b0 || o_timeout !== 1'b0)
      begin bad++; $display("FAIL arst_data: data=%h grant=%0d ready=%b timeout=%b want 00 0 0000 0", o_tx_data, o_grant_id, o_req_ready, o_timeout); end
    apply_reset();
    @(negedge clk); #2;
    push_exp(0, 8'h30, 0);
    push_exp(3, 8'h33, 3);
    push_byte(3, 8'h33);
    push_byte(0, 8'h30);
    prev_rdy = o_tx_ready;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk); #2;
      if (o_tx_ready && !prev_rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL arst_extra_issue: grant=%0d data=%h", o_grant_id, o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (o_grant_id !== e.id || o_tx_data !== e.data) begin
            bad++; $display("FAIL arst_issue: grant=%0d data=%h want grant=%0d data=%h", o_grant_id, o_tx_data, e.id, e.data);
          end
          if (e.gap != 0) begin
            total++;
            if (cyc - done_cyc != e.gap) begin bad++; $display("FAIL arst_gap: got %0d want %0d", cyc - done_cyc, e.gap); end
          end
        end
      end
      if (i_tx_done) done_cyc = cyc;
      prev_rdy = o_tx_ready;
      if (exp_q.size() == 0 && !o_busy && cyc > 0) break;
    end
    total++; if (exp_q.size() != 0 || o_busy)
      begin bad++; $display("FAIL arst_drain: pending=%0d busy=%b want 0 0", exp_q.size(), o_busy); end
    $display("test_async_reset finished");
  endtask

  task automatic test_stray_done();
    bit   prev_rdy = 1'b0;
    bit   seen = 1'b0;
    exp_t e;
    apply_reset();
    @(negedge clk); #2;
    i_tx_done = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); #2;
      i_tx_done = 1'b0;
      total++; if (o_busy !== 1'b0 || o_tx_ready !== 1'b0 || o_req_ready !== 4'b0)
        begin bad++; $display("FAIL stray_done: busy=%b tx_ready=%b ready=%b want 0 0 0000", o_busy, o_tx_ready, o_req_ready); end
    end
    push_exp(2, 8'h42, 0);
    push_byte(2, 8'h42);
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk); #2;
      if (o_tx_ready && !prev_rdy) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        total++; if (o_grant_id !== e.id || o_tx_data !== e.data)
          begin bad++; $display("FAIL stray_issue: grant=%0d data=%h want grant=%0d data=%h", o_grant_id, o_tx_data, e.id, e.data); end
      end
      prev_rdy = o_tx_ready;
    end
    total++; if (!seen) begin bad++; $display("FAIL stray_no_issue: tx_ready=%b want a rise", o_tx_ready); end
    $display("test_stray_done finished");
  endtask

  task automatic test_timeout();
    bit prev_rdy = 1'b0;
    bit seen = 1'b0;
    int hi_cnt = 0;
    int to_cnt = 0;
    apply_reset();
    model_en = 1'b0;
    @(negedge clk); #2;
    push_byte(1, 8'h99);
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk); #2;
      if (o_tx_ready && !prev_rdy) seen = 1'b1;
      prev_rdy = o_tx_ready;
    end
    total++; if (!seen) begin bad++; $display("FAIL to_no_issue: tx_ready=%b want a rise", o_tx_ready); end
`ifdef UART_TX_SCHED_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      @(negedge clk); #2;
      if (o_tx_ready) hi_cnt++;
      if (o_timeout) to_cnt++;
    end
    total++; if (hi_cnt != TIMEOUT_CYCLES - 1 || to_cnt != 0)
      begin bad++; $display("FAIL to_wait: ready_cycles=%0d timeouts=%0d want %0d 0", hi_cnt, to_cnt, TIMEOUT_CYCLES - 1); end
    @(negedge clk); #2;
    total++; if (o_timeout !== 1'b1 || o_tx_ready !== 1'b0 || o_busy !== 1'b0)
      begin bad++; $display("FAIL to_pulse: timeout=%b tx_ready=%b busy=%b want 1 0 0", o_timeout, o_tx_ready, o_busy); end
    @(negedge clk); #2;
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_len: timeout=%b want 0", o_timeout); end
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #2;
      if (o_tx_ready) hi_cnt++;
      if (o_timeout) to_cnt++;
    end
    total++; if (hi_cnt != 100 || to_cnt != 0)
      begin bad++; $display("FAIL to_hold: ready_cycles=%0d timeouts=%0d want 100 0", hi_cnt, to_cnt); end
`endif
    model_en = 1'b1;
    apply_reset();
    $display("test_timeout finished: ready_cycles=%0d", hi_cnt);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_async_reset();
    test_stray_done();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
